// File: rtl/uart_fifo_core.sv
// UART core with byte-wide register bus, independent TX/RX FIFOs, programmable
// bit period, optional parity, loopback, sticky error flags and level interrupt.
module uart_fifo_core #(
   parameter int DATA_W      = 8,
   parameter int FIFO_DEPTH  = 8,
   parameter int DEFAULT_DIV = 15
) (
   input  logic       clk,
   input  logic       arst,
   input  logic       ce,
   input  logic       we,
   input  logic [1:0] adr,
   input  logic [7:0] dat_in,
   output logic [7:0] dat_out,
   input  logic       rx,
   output logic       tx,
   input  logic       dis_int,
   output logic       inter
);

   localparam int         AW       = $clog2(FIFO_DEPTH);
   localparam logic [2:0] LAST_IDX = 3'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   logic w_wr_data, w_wr_ctrl, w_wr_div, w_rd, w_rd_data, w_rd_status;

   assign w_wr_data   = ce &  we & (adr == 2'd0);
   assign w_wr_ctrl   = ce &  we & (adr == 2'd2);
   assign w_wr_div    = ce &  we & (adr == 2'd3);
   assign w_rd        = ce & ~we;
   assign w_rd_data   = w_rd & (adr == 2'd0);
   assign w_rd_status = w_rd & (adr == 2'd1);

   logic [4:0] r_ctrl;
   logic [7:0] r_div;
   logic       r_overrun, r_frame_err, r_parity_err;
   logic       r_inter;
   logic [7:0] r_dat_out;

   // ---------------- FIFOs ----------------
   logic [DATA_W-1:0] r_txf_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] r_rxf_mem [FIFO_DEPTH];
   logic [AW:0]       r_txf_wp, r_txf_rp, r_rxf_wp, r_rxf_rp;
   logic              w_txf_empty, w_txf_full, w_txf_push, w_txf_pop;
   logic              w_rxf_empty, w_rxf_full, w_rxf_push, w_rxf_pop;
   logic [DATA_W-1:0] w_txf_head, w_rxf_head, w_rx_word;

   assign w_txf_empty = (r_txf_wp == r_txf_rp);
   assign w_txf_full  = (r_txf_wp[AW] != r_txf_rp[AW]) && (r_txf_wp[AW-1:0] == r_txf_rp[AW-1:0]);
   assign w_rxf_empty = (r_rxf_wp == r_rxf_rp);
   assign w_rxf_full  = (r_rxf_wp[AW] != r_rxf_rp[AW]) && (r_rxf_wp[AW-1:0] == r_rxf_rp[AW-1:0]);
   assign w_txf_head  = r_txf_mem[r_txf_rp[AW-1:0]];
   assign w_rxf_head  = r_rxf_mem[r_rxf_rp[AW-1:0]];

   // A full FIFO still accepts a push when an entry leaves on the same edge.
   assign w_txf_push  = w_wr_data & (~w_txf_full | w_txf_pop);
   assign w_rxf_pop   = w_rd_data & ~w_rxf_empty;

   // NOTE: storage arrays carry no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (w_txf_push) r_txf_mem[r_txf_wp[AW-1:0]] <= dat_in[DATA_W-1:0];
      if (w_rxf_push) r_rxf_mem[r_rxf_wp[AW-1:0]] <= w_rx_word;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (arst) begin
         r_txf_wp <= '0;
         r_txf_rp <= '0;
         r_rxf_wp <= '0;
         r_rxf_rp <= '0;
      end else begin
         if (w_txf_push) r_txf_wp <= r_txf_wp + (AW+1)'(1);
         if (w_txf_pop)  r_txf_rp <= r_txf_rp + (AW+1)'(1);
         if (w_rxf_push) r_rxf_wp <= r_rxf_wp + (AW+1)'(1);
         if (w_rxf_pop)  r_rxf_rp <= r_rxf_rp + (AW+1)'(1);
      end
   end

   // ---------------- transmitter ----------------
   state_t            r_tx_state, w_tx_state_nxt;
   logic [7:0]        r_tx_cnt, w_tx_cnt_nxt, r_tx_div, w_tx_div_nxt;
   logic [DATA_W-1:0] r_tx_data, w_tx_data_nxt;
   logic [2:0]        r_tx_idx, w_tx_idx_nxt;
   logic              r_tx_par_en, w_tx_par_en_nxt, r_tx_par_bit, w_tx_par_bit_nxt;
   logic              r_tx, w_tx_nxt;
   logic              w_tx_tick, w_tx_load, w_tx_idle;

   assign w_tx_tick = (r_tx_cnt == r_tx_div);
   assign w_tx_idle = w_txf_empty & (r_tx_state == S_IDLE);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_tx_state_nxt   = r_tx_state;
      w_tx_div_nxt     = r_tx_div;
      w_tx_data_nxt    = r_tx_data;
      w_tx_idx_nxt     = r_tx_idx;
      w_tx_par_en_nxt  = r_tx_par_en;
      w_tx_par_bit_nxt = r_tx_par_bit;
      w_tx_nxt         = r_tx;
      w_tx_load        = 1'b0;
      w_txf_pop        = 1'b0;
      w_tx_cnt_nxt     = (r_tx_state == S_IDLE || w_tx_tick) ? 8'd0 : r_tx_cnt + 8'd1;
      case (r_tx_state)
         S_IDLE:  if (!w_txf_empty) w_tx_load = 1'b1;
         S_START: if (w_tx_tick) begin
            w_tx_state_nxt = S_DATA;
            w_tx_idx_nxt   = 3'd0;
            w_tx_nxt       = r_tx_data[0];
         end
         S_DATA: if (w_tx_tick) begin
            if (r_tx_idx == LAST_IDX) begin
               w_tx_state_nxt = r_tx_par_en ? S_PARITY : S_STOP;
               w_tx_nxt       = r_tx_par_en ? r_tx_par_bit : 1'b1;
            end else begin
               w_tx_idx_nxt  = r_tx_idx + 3'd1;
               w_tx_data_nxt = r_tx_data >> 1;
               w_tx_nxt      = r_tx_data[1];
            end
         end
         S_PARITY: if (w_tx_tick) begin
            w_tx_state_nxt = S_STOP;
            w_tx_nxt       = 1'b1;
         end
         S_STOP: if (w_tx_tick) begin
            if (!w_txf_empty) w_tx_load = 1'b1;
            else              w_tx_state_nxt = S_IDLE;
         end
         default: begin
            w_tx_state_nxt = S_IDLE;
            w_tx_nxt       = 1'b1;
         end
      endcase
      // Frame start: the bit period and parity mode are frozen for the whole frame.
      if (w_tx_load) begin
         w_txf_pop        = 1'b1;
         w_tx_state_nxt   = S_START;
         w_tx_nxt         = 1'b0;
         w_tx_data_nxt    = w_txf_head;
         w_tx_div_nxt     = r_div;
         w_tx_par_en_nxt  = r_ctrl[2];
         w_tx_par_bit_nxt = (^w_txf_head) ^ r_ctrl[3];
      end
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         r_tx_state   <= S_IDLE;
         r_tx_cnt     <= '0;
         r_tx_div     <= 8'(DEFAULT_DIV);
         r_tx_data    <= '0;
         r_tx_idx     <= '0;
         r_tx_par_en  <= 1'b0;
         r_tx_par_bit <= 1'b0;
         r_tx         <= 1'b1;
      end else begin
         r_tx_state   <= w_tx_state_nxt;
         r_tx_cnt     <= w_tx_cnt_nxt;
         r_tx_div     <= w_tx_div_nxt;
         r_tx_data    <= w_tx_data_nxt;
         r_tx_idx     <= w_tx_idx_nxt;
         r_tx_par_en  <= w_tx_par_en_nxt;
         r_tx_par_bit <= w_tx_par_bit_nxt;
         r_tx         <= w_tx_nxt;
      end
   end

   // ---------------- receiver ----------------
   logic              r_rx_s1, r_rx_s2, r_rx_prev, w_rx_in;
   state_t            r_rx_state, w_rx_state_nxt;
   logic [7:0]        r_rx_cnt, w_rx_cnt_nxt, r_rx_div, w_rx_div_nxt;
   logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
   logic [2:0]        r_rx_idx, w_rx_idx_nxt;
   logic              r_rx_par_en, w_rx_par_en_nxt, r_rx_par_odd, w_rx_par_odd_nxt;
   logic              r_rx_par_bit, w_rx_par_bit_nxt;
   logic [8:0]        w_rx_half_m1;
   logic              w_rx_tick, w_rx_done, w_rx_good, w_rx_frame_err, w_rx_par_err, w_rx_ovr;

   assign w_rx_in      = r_ctrl[4] ? r_tx : r_rx_s2;
   assign w_rx_half_m1 = (({1'b0, r_rx_div} + 9'd1) >> 1) - 9'd1;
   assign w_rx_tick    = (r_rx_state == S_START) ? ({1'b0, r_rx_cnt} == w_rx_half_m1)
                                                 : (r_rx_cnt == r_rx_div);

   always_comb begin
      w_rx_state_nxt   = r_rx_state;
      w_rx_div_nxt     = r_rx_div;
      w_rx_data_nxt    = r_rx_data;
      w_rx_idx_nxt     = r_rx_idx;
      w_rx_par_en_nxt  = r_rx_par_en;
      w_rx_par_odd_nxt = r_rx_par_odd;
      w_rx_par_bit_nxt = r_rx_par_bit;
      w_rx_done        = 1'b0;
      w_rx_cnt_nxt     = (r_rx_state == S_IDLE || w_rx_tick) ? 8'd0 : r_rx_cnt + 8'd1;
      case (r_rx_state)
         S_IDLE: if (r_rx_prev && !w_rx_in) begin
            w_rx_state_nxt   = S_START;
            w_rx_div_nxt     = r_div;
            w_rx_par_en_nxt  = r_ctrl[2];
            w_rx_par_odd_nxt = r_ctrl[3];
         end
         S_START: if (w_rx_tick) begin
            w_rx_state_nxt = w_rx_in ? S_IDLE : S_DATA;
            w_rx_idx_nxt   = 3'd0;
         end
         S_DATA: if (w_rx_tick) begin
            w_rx_data_nxt = {w_rx_in, r_rx_data[DATA_W-1:1]};
            if (r_rx_idx == LAST_IDX) w_rx_state_nxt = r_rx_par_en ? S_PARITY : S_STOP;
            else                      w_rx_idx_nxt   = r_rx_idx + 3'd1;
         end
         S_PARITY: if (w_rx_tick) begin
            w_rx_par_bit_nxt = w_rx_in;
            w_rx_state_nxt   = S_STOP;
         end
         S_STOP: if (w_rx_tick) begin
            w_rx_done      = 1'b1;
            w_rx_state_nxt = S_IDLE;
         end
         default: w_rx_state_nxt = S_IDLE;
      endcase
   end

   assign w_rx_word      = r_rx_data;
   assign w_rx_frame_err = w_rx_done & ~w_rx_in;
   assign w_rx_good      = w_rx_done &  w_rx_in;
   assign w_rx_par_err   = w_rx_good & r_rx_par_en & (r_rx_par_bit != ((^r_rx_data) ^ r_rx_par_odd));
   assign w_rxf_push     = w_rx_good & (~w_rxf_full | w_rxf_pop);
   assign w_rx_ovr       = w_rx_good & w_rxf_full & ~w_rxf_pop;

   always_ff @(posedge clk) begin
      if (arst) begin
         r_rx_s1      <= 1'b1;
         r_rx_s2      <= 1'b1;
         r_rx_prev    <= 1'b1;
         r_rx_state   <= S_IDLE;
         r_rx_cnt     <= '0;
         r_rx_div     <= 8'(DEFAULT_DIV);
         r_rx_data    <= '0;
         r_rx_idx     <= '0;
         r_rx_par_en  <= 1'b0;
         r_rx_par_odd <= 1'b0;
         r_rx_par_bit <= 1'b0;
      end else begin
         r_rx_s1      <= rx;
         r_rx_s2      <= r_rx_s1;
         r_rx_prev    <= w_rx_in;
         r_rx_state   <= w_rx_state_nxt;
         r_rx_cnt     <= w_rx_cnt_nxt;
         r_rx_div     <= w_rx_div_nxt;
         r_rx_data    <= w_rx_data_nxt;
         r_rx_idx     <= w_rx_idx_nxt;
         r_rx_par_en  <= w_rx_par_en_nxt;
         r_rx_par_odd <= w_rx_par_odd_nxt;
         r_rx_par_bit <= w_rx_par_bit_nxt;
      end
   end

   // ---------------- registers, read path, interrupt ----------------
   logic [7:0] w_status, w_rx_byte;

   assign w_status = {2'b00, r_parity_err, r_frame_err, r_overrun, w_tx_idle, w_txf_full, ~w_rxf_empty};

   always_comb begin
      w_rx_byte              = 8'h00;
      w_rx_byte[DATA_W-1:0]  = w_rxf_head;
      if (w_rxf_empty) w_rx_byte = 8'h00;
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         r_ctrl       <= '0;
         r_div        <= 8'(DEFAULT_DIV);
         r_overrun    <= 1'b0;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
         r_dat_out    <= '0;
         r_inter      <= 1'b0;
      end else begin
         if (w_wr_ctrl) r_ctrl <= dat_in[4:0];
         if (w_wr_div)  r_div  <= (dat_in < 8'd3) ? 8'd3 : dat_in;
         // A new error on the clearing edge wins over the STATUS read.
         r_overrun    <= w_rx_ovr       | (r_overrun    & ~w_rd_status);
         r_frame_err  <= w_rx_frame_err | (r_frame_err  & ~w_rd_status);
         r_parity_err <= w_rx_par_err   | (r_parity_err & ~w_rd_status);
         if (w_rd) begin
            case (adr)
               2'd0:    r_dat_out <= w_rx_byte;
               2'd1:    r_dat_out <= w_status;
               2'd2:    r_dat_out <= {3'b000, r_ctrl};
               default: r_dat_out <= r_div;
            endcase
         end
         r_inter <= ~dis_int & ((r_ctrl[0] & ~w_rxf_empty) | (r_ctrl[1] & w_tx_idle) |
                                r_overrun | r_frame_err | r_parity_err);
      end
   end

   assign dat_out = r_dat_out;
   assign inter   = r_inter;
   assign tx      = r_tx | r_ctrl[4];

endmodule
